// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo hash map write side.
// Contents: key width, response status codes, insert FSM states and the
// default hash coefficients.
package cuckoo_pkg;

  localparam int ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_UPDATED = 2'd1,
    ST_FAIL    = 2'd2
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_KICK
  } state_e;

  localparam logic [31:0] DEF_COE_A0 = 32'h6f23ffab;
  localparam logic [31:0] DEF_COE_B0 = 32'h1f23ffab;
  localparam logic [31:0] DEF_COE_A1 = 32'h2545f491;
  localparam logic [31:0] DEF_COE_B1 = 32'h9e3779b9;

endpackage

// File: rtl/cuckoo_hash_fn.sv
// Combinational multiplicative bucket hash.
// o_index = top LG_NUM_BUCKETS bits of (key_hi*COE_A + key_lo*COE_B) mod 2^64.
// Ports:
//   i_key   : 64-bit key
//   o_index : bucket index
module cuckoo_hash_fn
  import cuckoo_pkg::*;
#(
  parameter int          LG_NUM_BUCKETS = 2,
  parameter logic [31:0] COE_A          = DEF_COE_A0,
  parameter logic [31:0] COE_B          = DEF_COE_B0
) (
  input  logic [ADDR_WIDTH-1:0]     i_key,
  output logic [LG_NUM_BUCKETS-1:0] o_index
);

  logic [63:0] w_prod_a;
  logic [63:0] w_prod_b;
  logic [63:0] w_sum;

  assign w_prod_a = {32'd0, i_key[63:32]} * {32'd0, COE_A};
  assign w_prod_b = {32'd0, i_key[31:0]}  * {32'd0, COE_B};
  assign w_sum    = w_prod_a + w_prod_b;
  assign o_index  = w_sum[63 -: LG_NUM_BUCKETS];

endmodule

// File: rtl/cuckoo_insert_engine.sv
// Cuckoo hash map insert engine with two bucket tables (T0, T1) and a
// registered lookup port. Inserts resolve collisions by bounded displacement.
// Ports:
//   clk, rst                      : clock, async active-high reset
//   req_valid/req_ready           : insert handshake
//   req_key/req_value             : insert payload
//   resp_valid                    : one-cycle completion pulse
//   resp_status                   : 0=OK, 1=UPDATED, 2=FAIL
//   resp_key/resp_value           : entry of final write, or dropped entry
//   resp_table/resp_index         : location of final write (0 on FAIL)
//   lkp_valid/lkp_key             : lookup request
//   lkp_hit/lkp_value             : registered lookup result
module cuckoo_insert_engine
  import cuckoo_pkg::*;
#(
  parameter int          LG_NUM_BUCKETS = 2,
  parameter int          KEY_W          = ADDR_WIDTH,
  parameter int          VAL_W          = 32,
  parameter logic [31:0] COE_A0         = DEF_COE_A0,
  parameter logic [31:0] COE_B0         = DEF_COE_B0,
  parameter logic [31:0] COE_A1         = DEF_COE_A1,
  parameter logic [31:0] COE_B1         = DEF_COE_B1,
  parameter int          MAX_KICKS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [KEY_W-1:0]          req_key,
  input  logic [VAL_W-1:0]          req_value,
  output logic                      resp_valid,
  output logic [1:0]                resp_status,
  output logic [KEY_W-1:0]          resp_key,
  output logic [VAL_W-1:0]          resp_value,
  output logic                      resp_table,
  output logic [LG_NUM_BUCKETS-1:0] resp_index,
  input  logic                      lkp_valid,
  input  logic [KEY_W-1:0]          lkp_key,
  output logic                      lkp_hit,
  output logic [VAL_W-1:0]          lkp_value
);

  localparam int NB = 1 << LG_NUM_BUCKETS;
  localparam int KW = $clog2(MAX_KICKS + 1);

  state_e                    r_state;
  state_e                    w_state_nxt;

  logic [KEY_W-1:0]          r_carry_key;
  logic [VAL_W-1:0]          r_carry_val;
  logic                      r_t;
  logic [KW-1:0]             r_kicks;

  logic                      r_tv   [2][NB];
  logic [KEY_W-1:0]          r_tk   [2][NB];
  logic [VAL_W-1:0]          r_tval [2][NB];

  logic [LG_NUM_BUCKETS-1:0] w_hc0, w_hc1, w_hl0, w_hl1, w_idx_t;
  logic                      w_hit0, w_hit1, w_occ_t, w_lh0, w_lh1;

  logic                      w_accept, w_wr_en, w_wr_tbl, w_swap, w_done;
  logic [LG_NUM_BUCKETS-1:0] w_wr_idx;
  status_e                   w_status;

  logic                      r_resp_valid;
  status_e                   r_resp_status;
  logic [KEY_W-1:0]          r_resp_key;
  logic [VAL_W-1:0]          r_resp_value;
  logic                      r_resp_table;
  logic [LG_NUM_BUCKETS-1:0] r_resp_index;
  logic                      r_lkp_hit;
  logic [VAL_W-1:0]          r_lkp_value;

  cuckoo_hash_fn #(.LG_NUM_BUCKETS(LG_NUM_BUCKETS), .COE_A(COE_A0), .COE_B(COE_B0))
    u_hash_c0 (.i_key(r_carry_key), .o_index(w_hc0));
  cuckoo_hash_fn #(.LG_NUM_BUCKETS(LG_NUM_BUCKETS), .COE_A(COE_A1), .COE_B(COE_B1))
    u_hash_c1 (.i_key(r_carry_key), .o_index(w_hc1));
  cuckoo_hash_fn #(.LG_NUM_BUCKETS(LG_NUM_BUCKETS), .COE_A(COE_A0), .COE_B(COE_B0))
    u_hash_l0 (.i_key(lkp_key), .o_index(w_hl0));
  cuckoo_hash_fn #(.LG_NUM_BUCKETS(LG_NUM_BUCKETS), .COE_A(COE_A1), .COE_B(COE_B1))
    u_hash_l1 (.i_key(lkp_key), .o_index(w_hl1));

  assign w_hit0  = r_tv[0][w_hc0] && (r_tk[0][w_hc0] == r_carry_key);
  assign w_hit1  = r_tv[1][w_hc1] && (r_tk[1][w_hc1] == r_carry_key);
  assign w_idx_t = r_t ? w_hc1 : w_hc0;
  assign w_occ_t = r_tv[r_t][w_idx_t];

  assign w_lh0 = r_tv[0][w_hl0] && (r_tk[0][w_hl0] == lkp_key);
  assign w_lh1 = r_tv[1][w_hl1] && (r_tk[1][w_hl1] == lkp_key);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Every table write stores the carry; only the target slot differs. A swap
  // is a write plus loading the evicted entry back into the carry.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_tbl    = 1'b0;
    w_wr_idx    = '0;
    w_swap      = 1'b0;
    w_done      = 1'b0;
    w_status    = ST_OK;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_PROBE;
        end
      end
      S_PROBE: begin
        w_wr_en = 1'b1;
        if (w_hit0) begin
          w_wr_idx = w_hc0;
          w_status = ST_UPDATED;
          w_done   = 1'b1;
        end else if (w_hit1) begin
          w_wr_tbl = 1'b1;
          w_wr_idx = w_hc1;
          w_status = ST_UPDATED;
          w_done   = 1'b1;
        end else if (!r_tv[0][w_hc0]) begin
          w_wr_idx = w_hc0;
          w_done   = 1'b1;
        end else if (!r_tv[1][w_hc1]) begin
          w_wr_tbl = 1'b1;
          w_wr_idx = w_hc1;
          w_done   = 1'b1;
        end else begin
          w_wr_idx    = w_hc0;
          w_swap      = 1'b1;
          w_state_nxt = S_KICK;
        end
      end
      S_KICK: begin
        w_wr_tbl = r_t;
        w_wr_idx = w_idx_t;
        if (!w_occ_t) begin
          w_wr_en = 1'b1;
          w_done  = 1'b1;
        end else if (r_kicks == KW'(MAX_KICKS)) begin
          w_status = ST_FAIL;
          w_done   = 1'b1;
        end else begin
          w_wr_en = 1'b1;
          w_swap  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_done) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_carry_key <= '0;
      r_carry_val <= '0;
      r_t         <= 1'b0;
      r_kicks     <= '0;
    end else if (w_accept) begin
      r_carry_key <= req_key;
      r_carry_val <= req_value;
      r_t         <= 1'b0;
      r_kicks     <= '0;
    end else if (w_swap) begin
      r_carry_key <= r_tk[w_wr_tbl][w_wr_idx];
      r_carry_val <= r_tval[w_wr_tbl][w_wr_idx];
      r_t         <= ~w_wr_tbl;
      r_kicks     <= r_kicks + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tv   <= '{default: '0};
      r_tk   <= '{default: '0};
      r_tval <= '{default: '0};
    end else if (w_wr_en) begin
      r_tv[w_wr_tbl][w_wr_idx]   <= 1'b1;
      r_tk[w_wr_tbl][w_wr_idx]   <= r_carry_key;
      r_tval[w_wr_tbl][w_wr_idx] <= r_carry_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid  <= 1'b0;
      r_resp_status <= ST_OK;
      r_resp_key    <= '0;
      r_resp_value  <= '0;
      r_resp_table  <= 1'b0;
      r_resp_index  <= '0;
    end else begin
      r_resp_valid <= w_done;
      if (w_done) begin
        r_resp_status <= w_status;
        r_resp_key    <= r_carry_key;
        r_resp_value  <= r_carry_val;
        r_resp_table  <= (w_status == ST_FAIL) ? 1'b0 : w_wr_tbl;
        r_resp_index  <= (w_status == ST_FAIL) ? '0 : w_wr_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lkp_hit   <= 1'b0;
      r_lkp_value <= '0;
    end else if (lkp_valid) begin
      r_lkp_hit   <= w_lh0 || w_lh1;
      r_lkp_value <= w_lh0 ? r_tval[0][w_hl0] :
                     w_lh1 ? r_tval[1][w_hl1] : '0;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign resp_valid  = r_resp_valid;
  assign resp_status = r_resp_status;
  assign resp_key    = r_resp_key;
  assign resp_value  = r_resp_value;
  assign resp_table  = r_resp_table;
  assign resp_index  = r_resp_index;
  assign lkp_hit     = r_lkp_hit;
  assign lkp_value   = r_lkp_value;

endmodule

// File: tb/tb_cuckoo_insert_engine.sv
module tb_cuckoo_insert_engine;

  localparam int          LG    = 2;
  localparam int          NB    = 1 << LG;
  localparam int          MAXK  = 8;
  localparam longint unsigned CA0 = 64'h6f23ffab;
  localparam longint unsigned CB0 = 64'h1f23ffab;
  localparam longint unsigned CA1 = 64'h2545f491;
  localparam longint unsigned CB1 = 64'h9e3779b9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_key;
  logic [31:0]   req_value;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [63:0]   resp_key;
  logic [31:0]   resp_value;
  logic          resp_table;
  logic [LG-1:0] resp_index;
  logic          lkp_valid;
  logic [63:0]   lkp_key;
  logic          lkp_hit;
  logic [31:0]   lkp_value;

  int total = 0;
  int bad   = 0;

  // reference map: two tables of {valid, key, value}
  bit          mv   [2][NB];
  logic [63:0] mk   [2][NB];
  logic [31:0] mval [2][NB];

  int          last_st, last_lat;

  cuckoo_insert_engine #(
    .LG_NUM_BUCKETS(LG), .KEY_W(64), .VAL_W(32), .MAX_KICKS(MAXK)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_value(req_value),
    .resp_valid(resp_valid), .resp_status(resp_status),
    .resp_key(resp_key), .resp_value(resp_value),
    .resp_table(resp_table), .resp_index(resp_index),
    .lkp_valid(lkp_valid), .lkp_key(lkp_key),
    .lkp_hit(lkp_hit), .lkp_value(lkp_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hidx(int t, logic [63:0] k);
    longint unsigned hi, lo, a, b;
    hi = longint'(k[63:32]);
    lo = longint'(k[31:0]);
    a  = (t == 0) ? CA0 : CA1;
    b  = (t == 0) ? CB0 : CB1;
    return int'((hi * a + lo * b) >> (64 - LG));
  endfunction

  function automatic bit m_present(logic [63:0] k);
    return (mv[0][hidx(0, k)] && mk[0][hidx(0, k)] == k) ||
           (mv[1][hidx(1, k)] && mk[1][hidx(1, k)] == k);
  endfunction

  task automatic m_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < NB; i++) mv[t][i] = 1'b0;
  endtask

  // Cuckoo insertion straight from the algorithm: update in place, else free
  // slot, else displace alternately between tables up to MAXK times.
  task automatic m_insert(input logic [63:0] k, input logic [31:0] v,
                          output int st, output logic [63:0] rk, output logic [31:0] rv,
                          output int rt, output int ri, output int lat);
    int h0, h1, t, n, idx;
    logic [63:0] ck, tk;
    logic [31:0] cv, tv;
    h0 = hidx(0, k); h1 = hidx(1, k);
    st = 0; rk = k; rv = v; lat = 2;
    if (mv[0][h0] && mk[0][h0] == k) begin mval[0][h0] = v; st = 1; rt = 0; ri = h0; return; end
    if (mv[1][h1] && mk[1][h1] == k) begin mval[1][h1] = v; st = 1; rt = 1; ri = h1; return; end
    if (!mv[0][h0]) begin mv[0][h0] = 1; mk[0][h0] = k; mval[0][h0] = v; rt = 0; ri = h0; return; end
    if (!mv[1][h1]) begin mv[1][h1] = 1; mk[1][h1] = k; mval[1][h1] = v; rt = 1; ri = h1; return; end
    ck = k; cv = v; t = 0; n = 0;
    forever begin
      idx = hidx(t, ck);
      tk = mk[t][idx]; tv = mval[t][idx];
      mk[t][idx] = ck; mval[t][idx] = cv;
      ck = tk; cv = tv;
      t = 1 - t; n++; lat = 2 + n;
      idx = hidx(t, ck);
      if (!mv[t][idx]) begin
        mv[t][idx] = 1; mk[t][idx] = ck; mval[t][idx] = cv;
        rk = ck; rv = cv; rt = t; ri = idx; return;
      end
      if (n == MAXK) begin st = 2; rk = ck; rv = cv; rt = 0; ri = 0; return; end
    end
  endtask

  task automatic do_insert(input logic [63:0] k, input logic [31:0] v);
    int st, rt, ri, lat, got_lat;
    logic [63:0] rk;
    logic [31:0] rv;
    m_insert(k, v, st, rk, rv, rt, ri, lat);
    req_valid = 1'b1; req_key = k; req_value = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_not_ready", req_ready, 0);
    got_lat = 0;
    for (int c = 1; c <= MAXK + 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid) begin got_lat = c + 1; break; end
    end
    last_st = resp_status; last_lat = got_lat;
    if (got_lat == 0) begin
      chk("resp_timeout", 0, 1);
      return;
    end
    chk("latency", got_lat, lat);
    chk("status", resp_status, st);
    chk("resp_key", resp_key, rk);
    chk("resp_value", resp_value, rv);
    chk("resp_table", resp_table, rt);
    chk("resp_index", resp_index, ri);
    chk("ready_on_resp", req_ready, 1);
    @(posedge clk); #1;
    chk("resp_pulse_width", resp_valid, 0);
  endtask

  task automatic do_lookup(input logic [63:0] k);
    bit eh;
    logic [31:0] ev;
    eh = 0; ev = '0;
    if (mv[0][hidx(0, k)] && mk[0][hidx(0, k)] == k) begin eh = 1; ev = mval[0][hidx(0, k)]; end
    else if (mv[1][hidx(1, k)] && mk[1][hidx(1, k)] == k) begin eh = 1; ev = mval[1][hidx(1, k)]; end
    lkp_valid = 1'b1; lkp_key = k;
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    chk("lkp_hit", lkp_hit, eh);
    chk("lkp_value", lkp_value, ev);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
  endtask

  function automatic logic [63:0] rkey();
    return {$urandom, $urandom};
  endfunction

  logic [63:0] ka, kb, kk, keys [9];
  logic [63:0] pool [10];
  int          fails, h, found;
  bit          saw_resp;
  logic        hold_hit;
  logic [31:0] hold_val;

  initial begin
    rst = 1'b1; req_valid = 0; req_key = '0; req_value = '0; lkp_valid = 0; lkp_key = '0;
    m_clear();
    #2;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_lkp_hit", lkp_hit, 0);
    chk("rst_lkp_value", lkp_value, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ready_after_rst", req_ready, 1);

    // first insert into empty map
    ka = 64'hffbbbbbbffbbbbbb;
    do_insert(ka, 32'h1);
    chk("first_status", last_st, 0);
    chk("first_table", resp_table, 0);
    chk("first_index", resp_index, 2);
    chk("first_latency", last_lat, 2);
    do_lookup(ka);
    chk("first_lkp_val", lkp_value, 32'h1);
    do_insert(ka, 32'h5);
    chk("upd_status", last_st, 1);
    chk("upd_index", resp_index, 2);
    do_lookup(ka);
    chk("upd_lkp_val", lkp_value, 32'h5);
    // outputs hold while lkp_valid is low
    hold_hit = lkp_hit; hold_val = lkp_value;
    lkp_key = rkey();
    @(posedge clk); #1;
    chk("lkp_hold_hit", lkp_hit, hold_hit);
    chk("lkp_hold_val", lkp_value, hold_val);

    // two keys sharing h0
    do_reset();
    ka = rkey();
    kb = rkey();
    for (int i = 0; i < 100000 && (hidx(0, kb) != hidx(0, ka) || kb == ka); i++) kb = rkey();
    do_insert(ka, $urandom);
    do_insert(kb, $urandom);
    chk("same_h0_table", resp_table, 1);
    chk("same_h0_lat", last_lat, 2);
    do_lookup(ka);
    do_lookup(kb);

    // one displacement: A in T0, B in T1[h1(K)], A's alternate free
    do_reset();
    ka = rkey();
    kk = rkey();
    for (int i = 0; i < 100000 && (hidx(0, kk) != hidx(0, ka) || hidx(1, kk) == hidx(1, ka)); i++) kk = rkey();
    kb = rkey();
    for (int i = 0; i < 100000 && (hidx(0, kb) != hidx(0, ka) || hidx(1, kb) != hidx(1, kk)); i++) kb = rkey();
    do_insert(ka, 32'haaaa);
    do_insert(kb, 32'hbbbb);
    do_insert(kk, 32'hcccc);
    chk("kick_status", last_st, 0);
    chk("kick_lat", last_lat, 3);
    chk("kick_table", resp_table, 1);
    chk("kick_reloc_key", resp_key, ka);
    do_lookup(ka);
    do_lookup(kb);
    do_lookup(kk);

    // nine distinct keys into eight slots
    do_reset();
    fails = 0;
    for (int i = 0; i < 9; i++) begin
      keys[i] = rkey();
      do_insert(keys[i], $urandom);
      if (last_st == 2) fails++;
      chk("lat_bound", last_lat <= MAXK + 2, 1);
    end
    chk("overflow_has_fail", fails >= 1, 1);
    for (int i = 0; i < 9; i++) do_lookup(keys[i]);

    // reset while displacing
    found = 0;
    for (int i = 0; i < 100000 && found == 0; i++) begin
      kk = rkey();
      if (mv[0][hidx(0, kk)] && mv[1][hidx(1, kk)] && !m_present(kk)) found = 1;
    end
    chk("kick_key_found", found, 1);
    for (int t = 0; t < 2; t++) for (int i = 0; i < NB; i++)
      if (mv[t][i]) ka = mk[t][i];
    do_lookup(ka);
    req_valid = 1'b1; req_key = kk; req_value = 32'hdead;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_lkp_hit", lkp_hit, 0);
    chk("midrst_lkp_value", lkp_value, 0);
    chk("midrst_resp_key", resp_key, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_clear();
    saw_resp = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (resp_valid) saw_resp = 1;
    end
    chk("midrst_no_resp", saw_resp, 0);
    for (int i = 0; i < 9; i++) do_lookup(keys[i]);
    do_lookup(kk);
    do_insert(rkey(), 32'h77);
    chk("post_rst_ok", last_st, 0);

    // random mix over a small key pool so updates and overflow both occur
    do_reset();
    for (int i = 0; i < 10; i++) pool[i] = rkey();
    for (int op = 0; op < 60; op++) begin
      h = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 6) do_insert(pool[h], $urandom);
      else if ($urandom_range(0, 3) == 0) do_lookup(rkey());
      else do_lookup(pool[h]);
    end
    for (int i = 0; i < 10; i++) do_lookup(pool[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cuckoo_insert_engine.md
Name: cuckoo_insert_engine

Overview:
Write side of the cuckoo hash map: accepts key/value insert requests and places them into two internal bucket tables (T0, T1), each indexed by its own multiplicative hash. It resolves collisions by iterative displacement ("kicking") under a bounded FSM. A registered lookup read port exposes table contents to the map's query path and to verification.

Parameters:
LG_NUM_BUCKETS, 2, log2 of bucket count per table (each table holds 2^LG_NUM_BUCKETS entries)
KEY_W, 64, key width (equal to ADDR_WIDTH)
VAL_W, 32, value width
COE_A0, 32'h6f23ffab, hash-0 upper-half coefficient
COE_B0, 32'h1f23ffab, hash-0 lower-half coefficient
COE_A1, 32'h2545f491, hash-1 upper-half coefficient
COE_B1, 32'h9e3779b9, hash-1 lower-half coefficient
MAX_KICKS, 8, displacement cycles allowed before FAIL

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  insert request valid
req_ready  out  1  engine idle, request accepted when valid&ready
req_key  in  KEY_W  key to insert
req_value  in  VAL_W  value to insert
resp_valid  out  1  one-cycle completion pulse, no backpressure
resp_status  out  2  0=OK new slot, 1=UPDATED existing key, 2=FAIL
resp_key  out  KEY_W  OK/UPDATED: inserted key; FAIL: dropped (homeless) key
resp_value  out  VAL_W  value paired with resp_key
resp_table  out  1  table of final write (0 on FAIL)
resp_index  out  LG_NUM_BUCKETS  bucket of final write (0 on FAIL)
lkp_valid  in  1  lookup request
lkp_key  in  KEY_W  lookup key
lkp_hit  out  1  registered, key present in T0[h0] or T1[h1]
lkp_value  out  VAL_W  registered value on hit, 0 on miss

Behaviour:
- Hash: h_t(k) = ((k[63:32]*COE_At + k[31:0]*COE_Bt) mod 2^64) >> (64-LG_NUM_BUCKETS). Each product is a 64-bit zero-extended unsigned product, the sum wraps at 64 bits, and the index is the top LG_NUM_BUCKETS bits.
- Table entry: {valid, key, value}. Reset clears all valid bits.
- Reset (async): state=IDLE, req_ready=1 after release, all resp_* and lkp_* outputs 0. Reset mid-insert aborts it with no response.
- FSM IDLE/PROBE/KICK:
  - IDLE: req_ready=1. On accept, latch key/value as carry, set t=0, kicks=0, go to PROBE.
  - PROBE (1 cycle):
    - If the carry key is valid in T0[h0], overwrite its value: UPDATED, table 0.
    - Else if it is valid in T1[h1], overwrite its value: UPDATED, table 1.
    - Else if T0[h0] is empty: write, OK.
    - Else if T1[h1] is empty: write, OK.
    - Else swap the carry with T0[h0], set t=1, kicks=1, go to KICK.
  - KICK (1 cycle per kick):
    - If Tt[h_t(carry)] is empty: write, OK, IDLE.
    - Else if kicks==MAX_KICKS: FAIL with the carry reported, tables untouched this cycle, IDLE.
    - Else swap, t^=1, kicks+1.
- Completion writes the table and registers resp_* at the same edge, and enters IDLE. resp_valid is high for exactly the following cycle, which is also the first cycle with req_ready=1.
- Latency: accept edge N; resp_valid in cycle N+2 for PROBE resolution, plus 1 per KICK cycle. Worst case MAX_KICKS+2.
- Throughput: one insert in flight. req_ready=0 in PROBE/KICK. req_valid is ignored while not ready.
- Lookup: registered, 1-cycle latency. Reads table state before any write on the same edge. Outputs hold when lkp_valid=0. lkp_hit is not required to be stable while an insert is in KICK.
- FAIL keeps every table entry unique. The dropped entry may be an earlier key, not the requested one.

Decomposition:
- Package cuckoo_pkg: ADDR_WIDTH=64, status encodings (ST_OK, ST_UPDATED, ST_FAIL), FSM state encodings, default coefficient constants.
- Sub-module cuckoo_hash_fn: combinational, parameterised by LG_NUM_BUCKETS, COE_A and COE_B. Instantiated for h0/h1 on the carry and for h0/h1 on lkp_key.

Test Plan:
- Reset, then insert key 64'hffbbbbbbffbbbbbb, value 32'h1 into the empty map -> resp_valid in cycle N+2, status OK, resp_table=0, resp_index=2; a subsequent lookup gives hit=1, value 1.
- Re-insert the same key with value 32'h5 -> status UPDATED, same table/index; lookup returns 5; no other entry changes.
- Insert two keys with equal h0 into an empty map -> second gets OK with resp_table=1, latency 2; both keys hit on lookup.
- Force a kick: fill T0[h0(K)] and T1[h1(K)], with an empty alternate slot for the T0 occupant -> K reports OK with latency 3, T0 occupant relocated to T1, all three keys hit.
- Insert 9 distinct keys (LG=2, 8 slots) -> at least one FAIL, latency never exceeds MAX_KICKS+2. All keys not reported as dropped still hit; reported keys miss.
- Assert rst while in KICK -> outputs 0 immediately, no resp_valid afterwards, all lookups miss, the next insert after release returns OK.
